// File: rtl/eq_coef_ctl_loader.sv
// Equaliser coefficient RAM loader: decodes toggle-handshaked control words into
// single writes or bulk fills (start..N_CHAN-1), with readback status counters.
module eq_coef_ctl_loader #(
  parameter int ADDR_W = 11,
  parameter int COEF_W = 16,
  parameter int N_CHAN = 2048
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctl_word,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [COEF_W-1:0] coef_data,
  output logic              coef_we,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic              overrun,
  output logic              addr_err
);

  localparam logic [2:0] ST_ARM   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_QUAL  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_FILL  = 3'd4;

  localparam logic [ADDR_W:0]   N_CHAN_W  = (ADDR_W+1)'(N_CHAN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CHAN - 1);

  logic [2:0]        state_reg;
  logic              ref_tog_reg;
  logic [31:0]       cand_reg;

  logic [ADDR_W-1:0] cand_addr;
  logic [COEF_W-1:0] cand_coef;
  logic              req_tog;
  logic              clr_status;
  logic              qual_stable;
  logic              addr_oob;
  logic              op_active;

  assign cand_addr   = cand_reg[16 +: ADDR_W];
  assign cand_coef   = cand_reg[0 +: COEF_W];
  assign req_tog     = ctl_word[31];
  assign clr_status  = ctl_word[29];
  assign qual_stable = (ctl_word == cand_reg);
  assign addr_oob    = ({1'b0, cand_addr} >= N_CHAN_W);
  assign op_active   = (state_reg == ST_WRITE) || (state_reg == ST_FILL);
  assign busy        = (state_reg != ST_IDLE);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_reg   <= ST_ARM;
      ref_tog_reg <= 1'b0;
      cand_reg    <= '0;
      coef_addr   <= '0;
      coef_data   <= '0;
      coef_we     <= 1'b0;
    end else begin
      case (state_reg)
        // Latch whatever toggle is present so a request left over from before reset is ignored.
        ST_ARM: begin
          ref_tog_reg <= req_tog;
          state_reg   <= ST_IDLE;
        end
        ST_IDLE: begin
          if (req_tog != ref_tog_reg) begin
            cand_reg  <= ctl_word;
            state_reg <= ST_QUAL;
          end
        end
        // Only act on a word seen unchanged for two cycles; software may update it piecewise.
        ST_QUAL: begin
          if (qual_stable) begin
            ref_tog_reg <= cand_reg[31];
            if (addr_oob) begin
              state_reg <= ST_IDLE;
            end else begin
              coef_addr <= cand_addr;
              coef_data <= cand_coef;
              coef_we   <= 1'b1;
              state_reg <= cand_reg[30] ? ST_FILL : ST_WRITE;
            end
          end else if (req_tog != ref_tog_reg) begin
            cand_reg <= ctl_word;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          coef_we     <= 1'b0;
          ref_tog_reg <= req_tog;
          state_reg   <= ST_IDLE;
        end
        ST_FILL: begin
          if (coef_addr == LAST_ADDR) begin
            coef_we     <= 1'b0;
            ref_tog_reg <= req_tog;
            state_reg   <= ST_IDLE;
          end else begin
            coef_addr <= coef_addr + 1'b1;
          end
        end
        default: begin
          coef_we   <= 1'b0;
          state_reg <= ST_ARM;
        end
      endcase
    end
  end

  // Status for readback; clear is a level and wins over any same-cycle update.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_count <= '0;
      overrun  <= 1'b0;
      addr_err <= 1'b0;
    end else if (clr_status) begin
      wr_count <= '0;
      overrun  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (coef_we && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (op_active && (req_tog != ref_tog_reg)) begin
        overrun <= 1'b1;
      end
      if ((state_reg == ST_QUAL) && qual_stable && addr_oob) begin
        addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eq_coef_ctl_loader.sv
// Directed bench for eq_coef_ctl_loader: one 2048-channel instance for the main
// sequences and one 2000-channel instance for out-of-range and last-channel cases.
module tb_eq_coef_ctl_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctl_word;
  logic [10:0] coef_addr;
  logic [15:0] coef_data;
  logic        coef_we;
  logic        busy;
  logic [15:0] wr_count;
  logic        overrun;
  logic        addr_err;

  logic [31:0] ctl2;
  logic [10:0] coef_addr2;
  logic [15:0] coef_data2;
  logic        coef_we2;
  logic        busy2;
  logic [15:0] wr_count2;
  logic        overrun2;
  logic        addr_err2;

  int checks;
  int failures;
  int n_we;

  eq_coef_ctl_loader #(.ADDR_W(11), .COEF_W(16), .N_CHAN(2048)) u_dut (
    .user_clk(clk), .user_rst_n(rst_n), .ctl_word(ctl_word),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_we(coef_we),
    .busy(busy), .wr_count(wr_count), .overrun(overrun), .addr_err(addr_err)
  );

  eq_coef_ctl_loader #(.ADDR_W(11), .COEF_W(16), .N_CHAN(2000)) u_dut2 (
    .user_clk(clk), .user_rst_n(rst_n), .ctl_word(ctl2),
    .coef_addr(coef_addr2), .coef_data(coef_data2), .coef_we(coef_we2),
    .busy(busy2), .wr_count(wr_count2), .overrun(overrun2), .addr_err(addr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ctl_word = 32'h0;
    ctl2     = 32'h0;
    tick(); tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(coef_we), 32'd0);
    check("rst_addr", 32'(coef_addr), 32'd0);
    check("rst_data", 32'(coef_data), 32'd0);
    check("rst_cnt", 32'(wr_count), 32'd0);
    check("rst_status", {30'd0, overrun, addr_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("arm_to_idle_busy", 32'(busy), 32'd0);
    $display("txn reset/arm done");

    // Single write
    ctl_word = 32'h8005_1234;
    tick();
    check("wr_lat1_we", 32'(coef_we), 32'd0);
    tick();
    check("wr_we", 32'(coef_we), 32'd1);
    check("wr_addr", 32'(coef_addr), 32'h005);
    check("wr_data", 32'(coef_data), 32'h1234);
    check("wr_busy", 32'(busy), 32'd1);
    tick();
    check("wr_we_drop", 32'(coef_we), 32'd0);
    check("wr_cnt", 32'(wr_count), 32'd1);
    check("wr_busy_low", 32'(busy), 32'd0);
    $display("txn single write addr=0x005 data=0x1234");

    // Fill 0x7FA..0x7FF
    ctl_word = 32'h47FA_00AB;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      check("fill_we", 32'(coef_we), 32'd1);
      check("fill_addr", 32'(coef_addr), 32'h7FA + 32'(i));
      check("fill_data", 32'(coef_data), 32'h00AB);
      tick();
    end
    check("fill_end_we", 32'(coef_we), 32'd0);
    check("fill_hold_addr", 32'(coef_addr), 32'h7FF);
    check("fill_cnt", 32'(wr_count), 32'd7);
    check("fill_busy_low", 32'(busy), 32'd0);
    $display("txn fill 0x7FA..0x7FF data=0x00AB");

    // Glitchy update: partial word one cycle, then final word
    ctl_word = 32'h8005_0000;
    tick();
    ctl_word = 32'h8009_5555;
    tick();
    check("glitch_no_early_we", 32'(coef_we), 32'd0);
    tick();
    check("glitch_we", 32'(coef_we), 32'd1);
    check("glitch_addr", 32'(coef_addr), 32'h009);
    check("glitch_data", 32'(coef_data), 32'h5555);
    tick();
    check("glitch_cnt", 32'(wr_count), 32'd8);
    $display("txn glitchy write addr=0x009 data=0x5555");

    // Toggle pulse withdrawn after one cycle
    ctl_word = 32'h0009_5555;
    tick();
    ctl_word = 32'h8009_5555;
    n_we = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (coef_we) n_we++;
    end
    check("pulse_no_we", 32'(n_we), 32'd0);
    check("pulse_cnt", 32'(wr_count), 32'd8);
    check("pulse_busy", 32'(busy), 32'd0);
    $display("txn withdrawn toggle pulse");

    // Overrun: full 2048-entry fill with toggle flipped mid-way
    ctl_word = 32'h4000_0077;
    tick(); tick();
    n_we = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!coef_we) break;
      n_we++;
      if (i == 10) ctl_word = 32'hC000_0077;
      tick();
    end
    check("ovr_fill_writes", 32'(n_we), 32'd2048);
    check("ovr_last_addr", 32'(coef_addr), 32'h7FF);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_cnt", 32'(wr_count), 32'd2056);
    n_we = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (coef_we) n_we++;
    end
    check("ovr_dropped", 32'(n_we), 32'd0);
    $display("txn overrun fill writes=%0d", 2048);

    // Clear status
    ctl_word = 32'hE000_0077;
    tick();
    check("clr_ovr", 32'(overrun), 32'd0);
    check("clr_cnt", 32'(wr_count), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    ctl_word = 32'hC000_0077;
    tick();
    $display("txn clr_status");

    // Reset in the middle of a fill
    ctl_word = 32'h4000_0011;
    tick(); tick();
    for (int i = 0; i < 256; i++) tick();
    check("mid_fill_addr", 32'(coef_addr), 32'h100);
    check("mid_fill_we", 32'(coef_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_we", 32'(coef_we), 32'd0);
    check("async_addr", 32'(coef_addr), 32'd0);
    check("async_data", 32'(coef_data), 32'd0);
    check("async_cnt", 32'(wr_count), 32'd0);
    check("async_busy", 32'(busy), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    n_we = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (coef_we) n_we++;
    end
    check("no_fill_restart", 32'(n_we), 32'd0);
    $display("txn reset during fill");

    // Stale toggle through reset release
    rst_n = 1'b0;
    ctl_word = 32'h8003_0042;
    tick(); tick();
    rst_n = 1'b1;
    n_we = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (coef_we) n_we++;
    end
    check("stale_no_we", 32'(n_we), 32'd0);
    check("stale_cnt", 32'(wr_count), 32'd0);
    $display("txn stale toggle ignored");

    // 2000-channel instance: out-of-range address
    ctl2 = 32'h87D0_0001;
    n_we = 0;
    tick(); if (coef_we2) n_we++;
    tick(); if (coef_we2) n_we++;
    tick(); if (coef_we2) n_we++;
    check("oob_addr_err", 32'(addr_err2), 32'd1);
    check("oob_no_we", 32'(n_we), 32'd0);
    check("oob_cnt", 32'(wr_count2), 32'd0);
    $display("txn addr 2000 rejected");

    // 2000-channel instance: fill starting at last channel writes once
    ctl2 = 32'h47CF_0002;
    tick(); tick();
    check("last_we", 32'(coef_we2), 32'd1);
    check("last_addr", 32'(coef_addr2), 32'h7CF);
    tick();
    check("last_we_drop", 32'(coef_we2), 32'd0);
    check("last_cnt", 32'(wr_count2), 32'd1);
    check("last_err_sticky", 32'(addr_err2), 32'd1);
    $display("txn fill from last channel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eq_coef_ctl_loader.md
Name: eq_coef_ctl_loader

Overview:
Downstream consumer of the eq2 control software register's user-side word (32-bit, already in user_clk domain). Decodes software write requests and drives the single-port write side of the equaliser coefficient RAM for 2048 channels. Supports single-coefficient writes and bulk fill from a start channel to the last channel. Exports status for a readback register.

Parameters:
ADDR_W, 11, channel address width
COEF_W, 16, coefficient width
N_CHAN, 2048, number of channels (<= 2^ADDR_W)

Ports:
user_clk  in  1  fabric clock, all logic on rising edge
user_rst_n  in  1  asynchronous active-low reset
ctl_word  in  32  control register value; [31] req toggle, [30] fill, [29] clr_status, [26:16] addr, [15:0] coef
coef_addr  out  ADDR_W  coefficient RAM write address
coef_data  out  COEF_W  coefficient RAM write data
coef_we  out  1  coefficient RAM write enable, one write per high cycle
busy  out  1  high in any state other than IDLE
wr_count  out  16  RAM writes performed, saturating at 0xFFFF
overrun  out  1  sticky: request toggled while busy
addr_err  out  1  sticky: request addr >= N_CHAN

Behaviour:
- Reset (async assert, sync release): state ARM; coef_addr, coef_data, coef_we, wr_count, overrun, addr_err all 0; ref_tog 0; busy 1.
- ARM (1 cycle after release): ref_tog <= ctl_word[31] with no write, so a stale toggle is not executed -> IDLE.
- IDLE: if ctl_word[31] != ref_tog: cand <= ctl_word -> QUAL.
- QUAL (stability check against partial multi-bit updates):
  - ctl_word == cand: ref_tog <= cand[31]. Then:
    - addr >= N_CHAN: addr_err <= 1 -> IDLE.
    - else if cand[30]: coef_addr <= addr -> FILL.
    - else -> WRITE.
  - ctl_word != cand and ctl_word[31] != ref_tog: cand <= ctl_word, stay in QUAL.
  - ctl_word[31] == ref_tog: toggle withdrawn -> IDLE, no write.
- WRITE: coef_we=1 for exactly one cycle with coef_addr=cand addr, coef_data=cand coef -> IDLE.
- FILL: coef_we=1 every cycle; coef_data=cand coef. coef_addr runs start, start+1, ... N_CHAN-1 inclusive, then -> IDLE. No wrap past N_CHAN-1. Start = N_CHAN-1 gives exactly 1 write.
- Latency: new toggle first presented at cycle t (IDLE). coef_we is high at cycle t+2.
- Outputs are registered. coef_addr and coef_data hold their last values when coef_we=0.
- wr_count: +1 per coef_we cycle; saturates at 0xFFFF.
- overrun: set if ctl_word[31] differs from the toggle latched at the start of the operation while in WRITE or FILL. The request is dropped. On return to IDLE, ref_tog <= ctl_word[31], so the dropped request never executes.
- clr_status (ctl_word[29]=1, level): wr_count, overrun and addr_err held at 0 while set. clr_status has priority over simultaneous increments or sets. It does not affect the FSM or writes.
- Reset asserted mid-FILL: coef_we drops immediately (async) and the fill is abandoned. After release, ARM re-syncs ref_tog, so the fill does not restart.

Test Plan:
- Single write: after ARM, set ctl_word=0x8005_1234 -> 2 cycles later exactly one coef_we with coef_addr=0x005, coef_data=0x1234; wr_count=1; busy low again next cycle.
- Fill: ctl_word toggles to 0x47FA_00AB (fill, addr 0x7FA) -> 6 consecutive coef_we, addrs 0x7FA..0x7FF, data 0x00AB; wr_count +6; no address wrap to 0.
- Glitchy update: ctl_word=0x8005_0000 for one cycle, then 0x8009_5555 held -> one write, addr 0x009, data 0x5555. A toggle pulse lasting one cycle then reverting -> no write.
- Overrun: start fill at addr 0x000, flip toggle mid-fill -> fill completes all 2048 writes; overrun=1; no extra write afterwards. Then set bit29=1 -> overrun=0, wr_count=0.
- Reset during fill at addr 0x100 -> coef_we=0 immediately, all outputs 0. After release with ctl_word unchanged -> no writes.
- Stale toggle at reset: ctl_word[31]=1 through reset release -> no write. With N_CHAN=2000 and a request to addr 2000 -> addr_err=1, no coef_we.
